// File: rtl/psddivide_seq.sv
// Sequential restoring integer divider with signed/unsigned mode, divide-by-zero
// and signed-overflow flags, a one-cycle done pulse and synchronous abort.
module psddivide_seq #(
  parameter int unsigned NBITS = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             run,
  input  logic             abort,
  input  logic             sgn,
  input  logic [NBITS-1:0] dividend,
  input  logic [NBITS-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] quotient,
  output logic [NBITS-1:0] rest,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(NBITS);
  localparam logic [CW-1:0]    CNT_LAST = CW'(NBITS - 1);
  localparam logic [NBITS-1:0] MIN_VAL  = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, INIT, ITER, FIX} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] a_q, a_d, b_q, b_d;
  logic [NBITS-1:0] dvd_q, dvd_d, dsr_q, dsr_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic             done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;
  logic [NBITS-1:0] quotient_q, quotient_d, rest_q, rest_d;
  logic [NBITS:0]   shifted, trial;

  // The remainder always stays below the divisor magnitude, so only the
  // working value needs the extra bit; the stored remainder is NBITS wide.
  assign shifted = {rem_q, dvd_q[NBITS-1]};
  assign trial   = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    sgn_d      = sgn_q;
    dvd_d      = dvd_q;
    dsr_d      = dsr_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    ovf_d      = ovf_q;
    quotient_d = quotient_q;
    rest_d     = rest_q;

    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (run) begin
            a_d     = dividend;
            b_d     = divisor;
            sgn_d   = sgn;
            state_d = INIT;
          end
        end
        INIT: begin
          dvd_d   = (sgn_q && a_q[NBITS-1]) ? -a_q : a_q;
          dsr_d   = (sgn_q && b_q[NBITS-1]) ? -b_q : b_q;
          neg_q_d = sgn_q & (a_q[NBITS-1] ^ b_q[NBITS-1]);
          neg_r_d = sgn_q & a_q[NBITS-1];
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (b_q == '0) ? FIX : ITER;
        end
        ITER: begin
          rem_d = trial[NBITS] ? shifted[NBITS-1:0] : trial[NBITS-1:0];
          dvd_d = {dvd_q[NBITS-2:0], ~trial[NBITS]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = FIX;
        end
        FIX: begin
          done_d  = 1'b1;
          state_d = IDLE;
          if (b_q == '0) begin
            quotient_d = '1;
            rest_d     = a_q;
            dz_d       = 1'b1;
            ovf_d      = 1'b0;
          end else begin
            quotient_d = neg_q_q ? -dvd_q : dvd_q;
            rest_d     = neg_r_q ? -rem_q : rem_q;
            dz_d       = 1'b0;
            ovf_d      = sgn_q && (a_q == MIN_VAL) && (b_q == '1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      sgn_q      <= 1'b0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
      quotient_q <= '0;
      rest_q     <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sgn_q      <= sgn_d;
      dvd_q      <= dvd_d;
      dsr_q      <= dsr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
      quotient_q <= quotient_d;
      rest_q     <= rest_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign quotient = quotient_q;
  assign rest     = rest_q;
  assign dz       = dz_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_psddivide_seq.sv
// Bench for psddivide_seq: arithmetic reference model checked every cycle plus
// directed vectors with hand-computed results, latencies and control scenarios.
module tb_psddivide_seq;

  localparam int unsigned NB = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          run = 1'b0;
  logic          abort = 1'b0;
  logic          sgn = 1'b0;
  logic [NB-1:0] dividend = '0;
  logic [NB-1:0] divisor = '0;
  logic          busy, done, dz, ovf;
  logic [NB-1:0] quotient, rest;

  psddivide_seq #(.NBITS(NB)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .abort(abort), .sgn(sgn),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .rest(rest), .dz(dz), .ovf(ovf)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: 64-bit signed math truncates toward zero and gives
  // the remainder the dividend's sign, which is exactly the required behaviour.
  function automatic void model_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z, output logic o);
    longint sa, sb, q64, r64;
    z = (b == 32'd0);
    o = 1'b0;
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa  = s ? longint'($signed(a)) : longint'({32'd0, a});
      sb  = s ? longint'($signed(b)) : longint'({32'd0, b});
      q64 = sa / sb;
      r64 = sa % sb;
      q   = q64[31:0];
      r   = r64[31:0];
      o   = s && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    end
  endfunction

  logic        m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, m_ovf = 1'b0, m_s = 1'b0;
  logic [31:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;
  int          m_left = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_ovf = 1'b0;
      m_q = '0; m_r = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (abort) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            model_div(m_a, m_b, m_s, m_q, m_r, m_dz, m_ovf);
            m_done = 1'b1;
            m_busy = 1'b0;
          end
        end
      end else if (run) begin
        m_a = dividend; m_b = divisor; m_s = sgn;
        m_left = (divisor == '0) ? 2 : int'(NB) + 2;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    check("cyc_busy", busy, m_busy);
    check("cyc_done", done, m_done);
    check("cyc_quotient", quotient, m_q);
    check("cyc_rest", rest, m_r);
    check("cyc_dz", dz, m_dz);
    check("cyc_ovf", ovf, m_ovf);
  end

  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] q, r;
    logic        z, o;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s,
                       output int unsigned k);
    dividend = a; divisor = b; sgn = s; run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int unsigned k, input int lat, input string name);
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check({name, "_done_seen"}, done, 1);
    check({name, "_latency"}, cyc - k, lat);
  endtask

  initial begin
    int unsigned k;
    int          dcount;
    logic [31:0] pq, pr;
    logic        pz, po;

    vecs = '{
      '{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 1'b0, 34},
      '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0, 34},
      '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0, 34},
      '{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0, 34},
      '{32'h1234,       32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0, 2},
      '{32'd9,          32'd3,          1'b0, 32'd3,          32'd0,          1'b0, 1'b0, 34},
      '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b1, 34},
      '{32'h8000_0000,  32'd1,          1'b1, 32'h8000_0000,  32'd0,          1'b0, 1'b0, 34},
      '{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 1'b0, 2},
      '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'h8000_0000,  1'b0, 1'b0, 34},
      '{32'd5,          32'd7,          1'b0, 32'd0,          32'd5,          1'b0, 1'b0, 34}
    };

    model_div(32'hFFFF_FFF9, 32'd2, 1'b1, pq, pr, pz, po);
    check("model_neg7_q", pq, 32'hFFFF_FFFD);
    check("model_neg7_r", pr, 32'hFFFF_FFFF);
    model_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, pq, pr, pz, po);
    check("model_ovf_q", pq, 32'h8000_0000);
    check("model_ovf_flag", po, 1'b1);

    repeat (3) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_rest", rest, 0);
    check("reset_flags", {dz, ovf}, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Back-to-back: each start follows the done cycle directly.
    foreach (vecs[i]) begin
      start(vecs[i].a, vecs[i].b, vecs[i].s, k);
      wait_done(k, vecs[i].lat, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_rest", i), rest, vecs[i].r);
      check($sformatf("vec%0d_dz", i), dz, vecs[i].z);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].o);
    end

    start(32'd100, 32'd7, 1'b0, k);
    wait_done(k, 34, "base");
    check("base_quotient", quotient, 32'd14);

    start(32'd100, 32'd7, 1'b0, k);
    while (cyc != k + 9) @(negedge clock);
    dividend = 32'd50; divisor = 32'd5; run = 1'b1;
    @(negedge clock);
    run = 1'b0;
    wait_done(k, 34, "ignored_run");
    check("ignored_run_quotient", quotient, 32'd14);
    check("ignored_run_rest", rest, 32'd2);

    abort = 1'b1;
    start(32'd9, 32'd3, 1'b0, k);
    abort = 1'b0;
    wait_done(k, 34, "run_beats_abort");
    check("run_beats_abort_quotient", quotient, 32'd3);

    start(32'd100, 32'd7, 1'b0, k);
    while (cyc != k + 4) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    dcount = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) dcount++;
    end
    check("abort_no_done", dcount, 0);
    check("abort_quotient_kept", quotient, 32'd3);
    check("abort_rest_kept", rest, 32'd0);

    start(32'd100, 32'd7, 1'b0, k);
    while (cyc != k + 19) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_quotient", quotient, 0);
    check("midreset_rest", rest, 0);
    check("midreset_flags", {done, dz, ovf}, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start(32'd100, 32'd7, 1'b0, k);
    wait_done(k, 34, "after_reset");
    check("after_reset_quotient", quotient, 32'd14);
    check("after_reset_rest", rest, 32'd2);

    repeat (3) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
